// File: rtl/adder_bist_pkg.sv
// ---------------------------------------------------------------------------
// adder_bist_pkg
// Shared definitions for the adder BIST engine.
//   - bist_state_t : engine sequencing states
//   - LFSR_MASK    : Galois feedback taps for x^64+x^63+x^61+x^60+1 (right shift)
//   - MISR_POLY    : feedback injected into the low bits when the MISR MSB shifts out
//   - bitrev       : 64-bit bit reversal used to derive operand b from the LFSR
// ---------------------------------------------------------------------------
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
    localparam logic [63:0] MISR_POLY = 64'h0000_0000_0000_001B;

    function automatic logic [63:0] bitrev(input logic [63:0] value);
        logic [63:0] rev;
        rev = '0;
        for (int i = 0; i < 64; i++) begin
            rev[i] = value[63 - i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/adder_bist_engine_lfsr.sv
// ---------------------------------------------------------------------------
// bist_lfsr64
// 64-bit right-shifting Galois LFSR used as the BIST pattern source.
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   async active-low reset, loads SEED
//   load   in   1   reload SEED (has priority over step)
//   step   in   1   advance one LFSR step
//   value  out  64  current LFSR contents
// ---------------------------------------------------------------------------
module bist_lfsr64
    import adder_bist_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h0123_4567_89AB_CDEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [63:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (step) begin
            // Bit shifted out of the LSB folds back in through the tap mask.
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 64'h0);
        end
    end

endmodule

// File: rtl/adder_bist_engine.sv
// ---------------------------------------------------------------------------
// adder_bist_engine
// BIST driver and response compactor for the 64-bit add/sub unit. Drives
// LFSR-derived operands into the adder, folds the returned sum/carry into a
// MISR and compares the final signature against GOLDEN_SIG.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      async active-low reset
//   start        in   1      run request, honoured in IDLE/DONE only
//   adder_a      out  WIDTH  operand a (LFSR state while running, else 0)
//   adder_b      out  WIDTH  operand b (bit-reversed LFSR while running, else 0)
//   adder_op     out  1      0=add, 1=subtract (alternates while running)
//   adder_sum    in   WIDTH  adder result
//   adder_carry  in   1      adder carry/borrow out
//   busy         out  1      high while issuing or draining
//   done         out  1      high once the run has finished, until next start
//   pass         out  1      valid with done; signature matched GOLDEN_SIG
//   signature    out  WIDTH  current MISR contents
// The LFSR/MISR polynomials are 64-bit, so WIDTH must stay at 64.
// ---------------------------------------------------------------------------
module adder_bist_engine
    import adder_bist_pkg::*;
#(
    parameter int               WIDTH         = 64,
    parameter int               N_PATTERNS    = 256,
    parameter int               ADDER_LATENCY = 1,
    parameter logic [WIDTH-1:0] SEED          = 64'h0123_4567_89AB_CDEF,
    parameter logic [WIDTH-1:0] GOLDEN_SIG    = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_op,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int CNT_W = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

    typedef logic [ADDER_LATENCY-1:0] vld_t;

    bist_state_t      state;
    bist_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    vld_t             vld_sr;
    vld_t             vld_next;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] misr;
    logic [WIDTH-1:0] misr_next;
    logic             start_ok;
    logic             in_run;
    logic             compact;

    bist_lfsr64 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .step  (in_run),
        .value (lfsr)
    );

    assign in_run  = (state == RUN);
    // Valid tags ride alongside the adder pipeline; the oldest tag marks the
    // cycle whose adder_sum belongs to an issued vector.
    assign vld_next = (vld_sr << 1) | vld_t'(in_run);
    assign compact  = vld_sr[ADDER_LATENCY-1];

    // Carry is folded into bit 0 so a carry-only fault still perturbs the signature.
    assign misr_next = {misr[WIDTH-2:0], 1'b0}
                     ^ (misr[WIDTH-1] ? MISR_POLY : 64'h0)
                     ^ {adder_sum[WIDTH-1:1], adder_sum[0] ^ adder_carry};

    assign adder_a   = in_run ? lfsr : '0;
    assign adder_b   = in_run ? bitrev(lfsr) : '0;
    assign adder_op  = in_run & cnt[0];
    assign signature = misr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave once the final in-flight result is compacted on this edge.
                if (vld_next == '0) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            vld_sr <= '0;
            misr   <= '0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            vld_sr <= vld_next;
            if (start_ok) begin
                cnt  <= '0;
                misr <= '0;
                done <= 1'b0;
                pass <= 1'b0;
            end else begin
                if (in_run) begin
                    cnt <= cnt + 1'b1;
                end
                if (compact) begin
                    misr <= misr_next;
                end
                // The verdict must include the compaction happening on this same edge.
                if (state == DRAIN && state_next == DONE) begin
                    done <= 1'b1;
                    pass <= ((compact ? misr_next : misr) == GOLDEN_SIG);
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_bist_engine.sv
// ---------------------------------------------------------------------------
// tb_adder_bist_engine
// Bench for adder_bist_engine with a registered fast adder (latency 1) and
// N_PATTERNS=4. A run-position model predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_adder_bist_engine;

    localparam int          N    = 4;
    localparam int          L    = 1;
    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

    function automatic logic [63:0] m_bitrev(input logic [63:0] v);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 64; i++) r[i] = v[63 - i];
        return r;
    endfunction

    // Operand a of vector idx: the LFSR after idx steps from SEED.
    function automatic logic [63:0] m_vec_a(input int idx);
        logic [63:0] s;
        s = SEED;
        for (int i = 0; i < idx; i++) s = (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
        return s;
    endfunction

    // {carry/borrow, sum}
    function automatic logic [64:0] m_adder(input logic [63:0] a, input logic [63:0] b, input logic op);
        return op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    // Signature after n compactions; stuck forces sum bit 0 to 1.
    function automatic logic [63:0] m_sig(input int n, input logic stuck);
        logic [63:0] m;
        logic [63:0] a;
        logic [64:0] r;
        m = 64'h0;
        for (int j = 0; j < n; j++) begin
            a = m_vec_a(j);
            r = m_adder(a, m_bitrev(a), j[0]);
            if (stuck) r[0] = 1'b1;
            m = {m[62:0], 1'b0} ^ (m[63] ? 64'h1B : 64'h0) ^ {r[63:1], r[0] ^ r[64]};
        end
        return m;
    endfunction

    localparam logic [63:0] GOLDEN = m_sig(N, 1'b0);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stuck;
    logic [63:0] adder_a, adder_b, adder_sum, signature;
    logic        adder_op, adder_carry, busy, done, pass;
    logic [63:0] sum_q = 64'h0;
    logic        carry_q = 1'b0;

    int tests = 0;
    int fails = 0;

    adder_bist_engine #(
        .WIDTH         (64),
        .N_PATTERNS    (N),
        .ADDER_LATENCY (L),
        .SEED          (SEED),
        .GOLDEN_SIG    (GOLDEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_op    (adder_op),
        .adder_sum   (adder_sum),
        .adder_carry (adder_carry),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    // Registered fast adder with an optional stuck-at-1 on sum bit 0.
    always @(posedge clk) {carry_q, sum_q} <= m_adder(adder_a, adder_b, adder_op);
    assign adder_sum   = sum_q | {63'h0, stuck};
    assign adder_carry = carry_q;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: runs are tracked by position k (edges since the accepted start edge).
    logic [63:0] vec_a [0:N-1];
    logic [63:0] sig_ok [0:N];
    logic [63:0] sig_bad [0:N];
    logic        active = 1'b0;
    int          k = 0;
    logic        stuck_run = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            k      <= 0;
        end else if (start && (!active || k >= N + L)) begin
            active    <= 1'b1;
            k         <= 0;
            stuck_run <= stuck;
        end else if (active) begin
            k <= k + 1;
        end
    end

    int          cj;
    logic [63:0] c_a, c_b, c_sig, c_final;
    logic        c_op, c_busy, c_done;

    always @(negedge clk) begin
        if (!rst_n || !active) begin
            chk("idle_a", adder_a, 64'h0);
            chk("idle_b", adder_b, 64'h0);
            chk("idle_op", {63'h0, adder_op}, 64'h0);
            chk("idle_busy", {63'h0, busy}, 64'h0);
            chk("idle_done", {63'h0, done}, 64'h0);
            chk("idle_pass", {63'h0, pass}, 64'h0);
            chk("idle_sig", signature, 64'h0);
        end else begin
            c_a  = 64'h0;
            c_b  = 64'h0;
            c_op = 1'b0;
            if (k < N) begin
                c_a  = vec_a[k];
                c_b  = m_bitrev(vec_a[k]);
                c_op = k[0];
            end
            cj = k - L;
            if (cj < 0) cj = 0;
            if (cj > N) cj = N;
            c_sig   = stuck_run ? sig_bad[cj] : sig_ok[cj];
            c_final = stuck_run ? sig_bad[N] : sig_ok[N];
            c_busy  = (k < N + L);
            c_done  = (k >= N + L);
            chk("run_a", adder_a, c_a);
            chk("run_b", adder_b, c_b);
            chk("run_op", {63'h0, adder_op}, {63'h0, c_op});
            chk("run_busy", {63'h0, busy}, {63'h0, c_busy});
            chk("run_done", {63'h0, done}, {63'h0, c_done});
            chk("run_pass", {63'h0, pass}, {63'h0, c_done && (c_final == GOLDEN)});
            chk("run_sig", signature, c_sig);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Starts a run and follows it until done (bounded). mid_start>0 re-pulses
    // start so that it is sampled on edge mid_start+1 of the run.
    task automatic do_run(input int mid_start, output int edges, output int busy_cnt,
                          output logic [3:0] ops, output logic [63:0] a0, output logic [63:0] b0);
        pulse_start();
        a0       = adder_a;
        b0       = adder_b;
        ops      = 4'h0;
        ops[0]   = adder_op;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        while (edges < 50) begin
            @(posedge clk); #1;
            edges++;
            start = (edges == mid_start);
            if (edges < 4) ops[edges] = adder_op;
            if (busy) busy_cnt++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    int          edges, busy_cnt;
    logic [3:0]  ops;
    logic [63:0] a0, b0;

    initial begin
        start = 1'b0;
        stuck = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) vec_a[i] = m_vec_a(i);
        for (int i = 0; i <= N; i++) begin
            sig_ok[i]  = m_sig(i, 1'b0);
            sig_bad[i] = m_sig(i, 1'b1);
        end
        #1 rst_n = 1'b0;

        // Hand-computed values pinning the model.
        chk("model_a0", vec_a[0], 64'h0123_4567_89AB_CDEF);
        chk("model_b0", m_bitrev(vec_a[0]), 64'hF7B3_D591_E6A2_C480);
        chk("model_a1", vec_a[1], 64'hD891_A2B3_C4D5_E6F7);
        chk("model_sum0", m_adder(vec_a[0], m_bitrev(vec_a[0]), 1'b0), 64'hF8D7_1AF9_704E_926F);
        chk("model_sig1", sig_ok[1], 64'hF8D7_1AF9_704E_926F);

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_a", adder_a, 64'h0);
        chk("rst_b", adder_b, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_sig", signature, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Fault-free run
        do_run(0, edges, busy_cnt, ops, a0, b0);
        chk("s3_first_a", a0, 64'h0123_4567_89AB_CDEF);
        chk("s3_first_b", b0, 64'hF7B3_D591_E6A2_C480);
        chk("s3_op_seq", {60'h0, ops}, 64'hA);
        chk("s3_busy_cycles", 64'(busy_cnt), 64'd5);
        chk("s3_done_edge", 64'(edges), 64'd5);
        chk("s3_pass", {63'h0, pass}, 64'h1);
        chk("s3_sig", signature, GOLDEN);

        // Stuck-at-1 on sum bit 0
        stuck = 1'b1;
        do_run(0, edges, busy_cnt, ops, a0, b0);
        chk("s4_done_edge", 64'(edges), 64'd5);
        chk("s4_pass", {63'h0, pass}, 64'h0);
        chk("s4_sig", signature, sig_bad[N]);
        tests++;
        if (signature === GOLDEN) begin
            fails++;
            $display("FAIL s4_sig_differs: got %h must not equal golden %h", signature, GOLDEN);
        end
        stuck = 1'b0;

        // Start during RUN is ignored
        do_run(1, edges, busy_cnt, ops, a0, b0);
        chk("s5_done_edge", 64'(edges), 64'd5);
        chk("s5_busy_cycles", 64'(busy_cnt), 64'd5);
        chk("s5_pass", {63'h0, pass}, 64'h1);
        chk("s5_sig", signature, GOLDEN);

        // Restart from DONE reproduces the signature
        do_run(0, edges, busy_cnt, ops, a0, b0);
        chk("s5_rerun_edge", 64'(edges), 64'd5);
        chk("s5_rerun_sig", signature, GOLDEN);
        chk("s5_rerun_pass", {63'h0, pass}, 64'h1);

        // Reset mid-run
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("s6_a", adder_a, 64'h0);
        chk("s6_b", adder_b, 64'h0);
        chk("s6_op", {63'h0, adder_op}, 64'h0);
        chk("s6_busy", {63'h0, busy}, 64'h0);
        chk("s6_done", {63'h0, done}, 64'h0);
        chk("s6_pass", {63'h0, pass}, 64'h0);
        chk("s6_sig", signature, 64'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        do_run(0, edges, busy_cnt, ops, a0, b0);
        chk("s6_rerun_edge", 64'(edges), 64'd5);
        chk("s6_rerun_pass", {63'h0, pass}, 64'h1);
        chk("s6_rerun_sig", signature, GOLDEN);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
